// File: rtl/key_buffer.sv
// Keyboard receive FIFO: one ASCII byte per key-press edge, popped by CPU reads at Key_base.
// Define KEY_BUFFER_IRQ_EN to include the interrupt FSM; otherwise interrupt_vector is tied to 0.
module key_buffer #(
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     key_pressed,
    input  logic [7:0]               ascii_code,
    input  logic                     bus_read_enable,
    input  logic                     key_selected,
    input  logic                     interrupt_ack,
    output logic [63:0]              bus_read_data,
    output logic [3:0]               interrupt_vector,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic            key_pressed_q, key_pressed_d;
    logic [PW-1:0]   wptr_q, wptr_d;
    logic [PW-1:0]   rptr_q, rptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            overflow_q, overflow_d;
    logic [63:0]     rd_data_q, rd_data_d;
    logic [7:0]      mem_q [DEPTH];

    logic push_c, pop_c, empty_c, full_c, wr_en_c, rd_en_c;

    assign push_c  = key_pressed & ~key_pressed_q & (ascii_code != 8'd0);
    assign pop_c   = bus_read_enable & key_selected;
    assign empty_c = (count_q == '0);
    assign full_c  = (count_q == CW'(DEPTH));
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign wr_en_c = push_c & (~full_c | pop_c);
    assign rd_en_c = pop_c & ~empty_c;

    always_comb begin
        key_pressed_d = key_pressed;
        wptr_d        = wptr_q;
        rptr_d        = rptr_q;
        count_d       = count_q;
        overflow_d    = overflow_q;
        rd_data_d     = rd_data_q;

        if (wr_en_c) wptr_d = wptr_q + PW'(1);
        if (rd_en_c) rptr_d = rptr_q + PW'(1);

        if (wr_en_c && !rd_en_c)      count_d = count_q + CW'(1);
        else if (rd_en_c && !wr_en_c) count_d = count_q - CW'(1);

        if (pop_c) begin
            overflow_d = 1'b0;
            rd_data_d  = {54'd0, overflow_q, rd_en_c, (rd_en_c ? mem_q[rptr_q] : 8'd0)};
        end
        if (push_c && full_c && !pop_c) overflow_d = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            key_pressed_q <= 1'b0;
            wptr_q        <= '0;
            rptr_q        <= '0;
            count_q       <= '0;
            overflow_q    <= 1'b0;
            rd_data_q     <= 64'd0;
        end else begin
            key_pressed_q <= key_pressed_d;
            wptr_q        <= wptr_d;
            rptr_q        <= rptr_d;
            count_q       <= count_d;
            overflow_q    <= overflow_d;
            rd_data_q     <= rd_data_d;
        end
    end

    // Storage needs no reset: pointers and count define which entries are live.
    always_ff @(posedge clk) begin
        if (wr_en_c) mem_q[wptr_q] <= ascii_code;
    end

    assign bus_read_data = rd_data_q;
    assign count         = count_q;
    assign overflow      = overflow_q;

`ifdef KEY_BUFFER_IRQ_EN
    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_PEND     = 2'd1,
        S_SERVICED = 2'd2
    } irq_state_e;

    irq_state_e  state_q, state_d;
    logic [3:0]  vec_q, vec_d;

    // SERVICED masks new pushes until the handler has drained the FIFO.
    always_comb begin
        state_d = state_q;
        vec_d   = 4'd0;
        case (state_q)
            S_IDLE: begin
                if (!empty_c) begin
                    state_d = S_PEND;
                    vec_d   = 4'd1;
                end
            end
            S_PEND: begin
                if (interrupt_ack) begin
                    state_d = S_SERVICED;
                end else begin
                    vec_d   = 4'd1;
                end
            end
            S_SERVICED: begin
                if (empty_c) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            vec_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
        end
    end

    assign interrupt_vector = vec_q;
`else
    logic irq_unused_c;
    assign irq_unused_c     = interrupt_ack;
    assign interrupt_vector = 4'd0;
`endif

endmodule

// File: tb/tb_key_buffer.sv
// Self-checking bench for key_buffer: directed test-plan steps followed by random traffic,
// all compared against a queue-based behavioural model.
module tb_key_buffer;

    localparam int unsigned DEPTH = 16;
`ifdef KEY_BUFFER_IRQ_EN
    localparam bit IRQ_EN = 1'b1;
`else
    localparam bit IRQ_EN = 1'b0;
`endif

    logic                   clk;
    logic                   reset;
    logic                   key_pressed;
    logic [7:0]             ascii_code;
    logic                   bus_read_enable;
    logic                   key_selected;
    logic                   interrupt_ack;
    logic [63:0]            bus_read_data;
    logic [3:0]             interrupt_vector;
    logic [$clog2(DEPTH):0] count;
    logic                   overflow;

    key_buffer #(.DEPTH(DEPTH)) dut (
        .clk              (clk),
        .reset            (reset),
        .key_pressed      (key_pressed),
        .ascii_code       (ascii_code),
        .bus_read_enable  (bus_read_enable),
        .key_selected     (key_selected),
        .interrupt_ack    (interrupt_ack),
        .bus_read_data    (bus_read_data),
        .interrupt_vector (interrupt_vector),
        .count            (count),
        .overflow         (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Behavioural model state
    logic [7:0]  mq [$];
    logic        m_ovf;
    logic [63:0] m_rd;
    logic        m_prev_kp;
    logic        m_irq;       // interrupt currently raised
    logic        m_handled;   // acknowledged, waiting for the FIFO to drain

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_ovf     = 1'b0;
        m_rd      = 64'd0;
        m_prev_kp = 1'b0;
        m_irq     = 1'b0;
        m_handled = 1'b0;
    endtask

    task automatic model_step(input logic kp, input logic [7:0] code,
                              input logic rd, input logic sel, input logic ack);
        int         occ;
        logic       push, pop;
        logic [7:0] b;
        occ  = mq.size();
        push = kp && !m_prev_kp && (code != 8'd0);
        pop  = rd && sel;
        // interrupt: raise on pending data, drop on ack, re-arm once drained
        if (m_irq && ack) begin
            m_irq     = 1'b0;
            m_handled = 1'b1;
        end else if (m_handled) begin
            if (occ == 0) m_handled = 1'b0;
        end else if (!m_irq && occ != 0) begin
            m_irq = 1'b1;
        end
        if (pop) begin
            if (occ > 0) begin
                b    = mq.pop_front();
                m_rd = {54'd0, m_ovf, 1'b1, b};
            end else begin
                m_rd = {54'd0, m_ovf, 1'b0, 8'd0};
            end
            m_ovf = 1'b0;
        end
        if (push) begin
            if (mq.size() < DEPTH) mq.push_back(code);
            else                   m_ovf = 1'b1;
        end
        m_prev_kp = kp;
    endtask

    task automatic check_all(input string tag);
        check({tag, ".count"},    64'(count),            64'(mq.size()));
        check({tag, ".overflow"}, 64'(overflow),         64'(m_ovf));
        check({tag, ".rdata"},    bus_read_data,         m_rd);
        check({tag, ".irq"},      64'(interrupt_vector), (IRQ_EN && m_irq) ? 64'd1 : 64'd0);
    endtask

    task automatic cycle(input logic kp, input logic [7:0] code,
                         input logic rd, input logic sel, input logic ack);
        key_pressed     = kp;
        ascii_code      = code;
        bus_read_enable = rd;
        key_selected    = sel;
        interrupt_ack   = ack;
        @(posedge clk);
        model_step(kp, code, rd, sel, ack);
        #1;
        check_all("cyc");
    endtask

    task automatic press(input logic [7:0] code);
        cycle(1'b1, code, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 8'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic read_key();
        cycle(1'b0, 8'd0, 1'b1, 1'b1, 1'b0);
    endtask

    task automatic idle();
        cycle(1'b0, 8'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic ack_irq();
        cycle(1'b0, 8'd0, 1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        reset           = 1'b1;
        key_pressed     = 1'b0;
        ascii_code      = 8'd0;
        bus_read_enable = 1'b0;
        key_selected    = 1'b0;
        interrupt_ack   = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset.rdata", bus_read_data, 64'd0);
        check("reset.count", 64'(count), 64'd0);
        check("reset.ovf", 64'(overflow), 64'd0);
        check("reset.irq", 64'(interrupt_vector), 64'd0);
        reset = 1'b0;

        // single press of 'a'
        cycle(1'b1, 8'h61, 1'b0, 1'b0, 1'b0);
        check("a.count", 64'(count), 64'd1);
        cycle(1'b1, 8'h61, 1'b0, 1'b0, 1'b0);   // still held: no second push
        check("a.held", 64'(count), 64'd1);
        check("a.irq", 64'(interrupt_vector), IRQ_EN ? 64'd1 : 64'd0);
        cycle(1'b0, 8'd0, 1'b1, 1'b1, 1'b0);
        check("a.read", bus_read_data, 64'h161);
        check("a.count0", 64'(count), 64'd0);
        ack_irq();
        idle();

        // three keys in order, then an empty read
        press(8'h41); press(8'h42); press(8'h43);
        read_key(); check("abc.0", bus_read_data, 64'h141);
        idle();
        check("abc.hold", bus_read_data, 64'h141);
        cycle(1'b0, 8'd0, 1'b1, 1'b0, 1'b0);     // read of another address
        check("abc.nonkey", bus_read_data, 64'h141);
        read_key(); check("abc.1", bus_read_data, 64'h142);
        read_key(); check("abc.2", bus_read_data, 64'h143);
        read_key(); check("abc.empty", bus_read_data, 64'h000);
        ack_irq(); idle();

        // zero bytes are never stored
        press(8'h00);
        check("zero.count", 64'(count), 64'd0);

        // overflow: 17 presses into 16 entries
        for (int i = 0; i < 17; i++) press(8'(8'h50 + i));
        check("ovf.count", 64'(count), 64'd16);
        check("ovf.flag", 64'(overflow), 64'd1);
        read_key(); check("ovf.read0", bus_read_data, 64'h350);
        check("ovf.cleared", 64'(overflow), 64'd0);
        read_key(); check("ovf.read1", bus_read_data, 64'h151);

        // refill, then simultaneous push and pop when full
        press(8'h70); press(8'h71);
        check("full.count", 64'(count), 64'd16);
        cycle(1'b1, 8'h7A, 1'b1, 1'b1, 1'b0);
        check("full.simul.count", 64'(count), 64'd16);
        check("full.simul.ovf", 64'(overflow), 64'd0);
        check("full.simul.rd", bus_read_data, 64'h152);
        idle();
        for (int i = 0; i < 16; i++) read_key();
        check("full.tail", bus_read_data, 64'h17A);
        check("full.drained", 64'(count), 64'd0);
        ack_irq(); idle(); idle();

        // interrupt sequence
        press(8'h31);
        check("irq.raise", 64'(interrupt_vector), IRQ_EN ? 64'd1 : 64'd0);
        ack_irq();
        check("irq.ack", 64'(interrupt_vector), 64'd0);
        press(8'h32); idle();
        check("irq.masked", 64'(interrupt_vector), 64'd0);
        read_key(); read_key(); idle();
        press(8'h33);
        check("irq.rearm", 64'(interrupt_vector), IRQ_EN ? 64'd1 : 64'd0);

        // asynchronous reset with five entries queued
        press(8'h34); press(8'h35); press(8'h36); press(8'h37);
        check("rst.count5", 64'(count), 64'd5);
        #2 reset = 1'b1;
        #1;
        model_reset();
        check("rst.count", 64'(count), 64'd0);
        check("rst.rdata", bus_read_data, 64'd0);
        check("rst.irq", 64'(interrupt_vector), 64'd0);
        check("rst.ovf", 64'(overflow), 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        read_key(); check("rst.read", bus_read_data, 64'h000);

        // random traffic
        for (int n = 0; n < 800; n++) begin
            cycle(1'($urandom_range(0, 1)),
                  ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(1, 255)),
                  ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 7) == 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
